// File: rtl/wb_port_arb_if.sv
// Bus interface for the register-file write-port arbiter.
// Signal names carry the i_/o_ prefix as seen from the arbiter, so the
// slave modport is the arbiter itself and the master modport is the
// surrounding pipeline / long-latency unit / register-file side.
interface wb_port_arb_if;
  logic        i_a_vld;
  logic [4:0]  i_a_addr;
  logic [31:0] i_a_data;
  logic        o_a_rdy;
  logic        i_b_vld;
  logic [4:0]  i_b_addr;
  logic [31:0] i_b_data;
  logic        o_b_rdy;
  logic        o_rf_we;
  logic [4:0]  o_rf_addr;
  logic [31:0] o_rf_data;

  modport master (
    output i_a_vld, i_a_addr, i_a_data,
    output i_b_vld, i_b_addr, i_b_data,
    input  o_a_rdy, o_b_rdy,
    input  o_rf_we, o_rf_addr, o_rf_data
  );

  modport slave (
    input  i_a_vld, i_a_addr, i_a_data,
    input  i_b_vld, i_b_addr, i_b_data,
    output o_a_rdy, o_b_rdy,
    output o_rf_we, o_rf_addr, o_rf_data
  );
endinterface

// File: rtl/wb_port_arb.sv
// wb_port_arb: shares the single register-file write port between the
// in-order pipeline writeback (source A) and the long-latency mul/div
// unit (source B). A results that cannot be written immediately are held
// in an in-order FIFO; B is protected from starvation by a wait counter
// that forces a one-cycle boost state in which B owns the port.
// Optional feature macro: WB_PORT_ARB_ZERO_FILTER_EN -- when defined,
// writes to register 0 are accepted but silently dropped.
module wb_port_arb #(
  parameter int FIFO_DEPTH = 2,
  parameter int WAIT_MAX   = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  wb_port_arb_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_NORM, S_BOOST} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [36:0]       r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_waitCnt;
  logic [3:0]        w_waitCntNext;
  logic              r_rfWe;
  logic [4:0]        r_rfAddr;
  logic [31:0]       r_rfData;

  logic              w_fifoEmpty;
  logic              w_aRdy;
  logic              w_aFire;
  logic              w_bRdy;
  logic              w_bFire;
  logic              w_aKeep;
  logic              w_bKeep;
  logic              w_push;
  logic              w_pop;
  logic              w_grantVld;
  logic [4:0]        w_grantAddr;
  logic [31:0]       w_grantData;

  assign w_fifoEmpty = (r_count == '0);
  assign w_aRdy      = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_aFire     = bus.i_a_vld & w_aRdy;
  assign w_bFire     = bus.i_b_vld & w_bRdy;

`ifdef WB_PORT_ARB_ZERO_FILTER_EN
  assign w_aKeep = (bus.i_a_addr != 5'd0);
  assign w_bKeep = (bus.i_b_addr != 5'd0);
`else
  assign w_aKeep = 1'b1;
  assign w_bKeep = 1'b1;
`endif

  assign bus.o_a_rdy   = w_aRdy;
  assign bus.o_b_rdy   = w_bRdy;
  assign bus.o_rf_we   = r_rfWe;
  assign bus.o_rf_addr = r_rfAddr;
  assign bus.o_rf_data = r_rfData;

  // FSM state and B wait counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_NORM;
      r_waitCnt <= 4'd0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitCntNext;
    end
  end

  // Next wait count and next state; boost lasts until B is served or withdraws
  always_comb begin
    w_waitCntNext = 4'd0;
    w_stateNext   = r_state;
    if (w_bFire || !bus.i_b_vld) begin
      w_waitCntNext = 4'd0;
    end else if (r_state == S_NORM) begin
      w_waitCntNext = r_waitCnt + 4'd1;
    end
    case (r_state)
      S_NORM: begin
        if (w_waitCntNext == 4'(WAIT_MAX)) begin
          w_stateNext = S_BOOST;
        end
      end
      S_BOOST: begin
        if (w_bFire || !bus.i_b_vld) begin
          w_stateNext = S_NORM;
        end
      end
      default: w_stateNext = S_NORM;
    endcase
  end

  // Grant selection, B ready, and FIFO push/pop decisions for each state
  always_comb begin
    w_bRdy      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_grantVld  = 1'b0;
    w_grantAddr = r_fifoMem[r_rdPtr][36:32];
    w_grantData = r_fifoMem[r_rdPtr][31:0];
    case (r_state)
      S_BOOST: begin
        w_bRdy = bus.i_b_vld;
        if (bus.i_b_vld) begin
          w_grantVld  = w_bKeep;
          w_grantAddr = bus.i_b_addr;
          w_grantData = bus.i_b_data;
        end
        w_push = w_aFire & w_aKeep;
      end
      default: begin
        if (!w_fifoEmpty) begin
          w_pop      = 1'b1;
          w_grantVld = 1'b1;
          w_push     = w_aFire & w_aKeep;
        end else if (bus.i_a_vld) begin
          w_grantVld  = w_aKeep;
          w_grantAddr = bus.i_a_addr;
          w_grantData = bus.i_a_data;
        end else if (bus.i_b_vld) begin
          w_bRdy      = 1'b1;
          w_grantVld  = w_bKeep;
          w_grantAddr = bus.i_b_addr;
          w_grantData = bus.i_b_data;
        end
      end
    endcase
  end

  // FIFO storage; contents are not reset because the pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= {bus.i_a_addr, bus.i_a_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port; address and data hold when nothing is granted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rfWe   <= 1'b0;
      r_rfAddr <= 5'd0;
      r_rfData <= 32'd0;
    end else begin
      r_rfWe <= w_grantVld;
      if (w_grantVld) begin
        r_rfAddr <= w_grantAddr;
        r_rfData <= w_grantData;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// Self-checking bench for wb_port_arb: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a queue-based reference
// model of the arbitration rules.
module tb_wb_port_arb;

  localparam int FIFO_DEPTH = 2;
  localparam int WAIT_MAX   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_port_arb_if bus ();

  wb_port_arb #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WAIT_MAX   (WAIT_MAX)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Reference model state
  logic [36:0] aQ [$];
  bit          mBoost;
  int          mWait;
  logic        mWe;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  bit          mAAccepted;
  bit          mBAccepted;

  int checkCount = 0;
  int passCount  = 0;

  // Held source state for randomized traffic
  logic        curAV = 1'b0;
  logic [4:0]  curAAddr = 5'd0;
  logic [31:0] curAData = 32'd0;
  logic        curBV = 1'b0;
  logic [4:0]  curBAddr = 5'd0;
  logic [31:0] curBData = 32'd0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    aQ.delete();
    mBoost     = 1'b0;
    mWait      = 0;
    mWe        = 1'b0;
    mAddr      = 5'd0;
    mData      = 32'd0;
    mAAccepted = 1'b0;
    mBAccepted = 1'b0;
  endtask

  function automatic bit isZeroDrop(input logic [4:0] addr);
`ifdef WB_PORT_ARB_ZERO_FILTER_EN
    return (addr == 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelWrite(input logic [4:0] addr, input logic [31:0] data);
    if (!isZeroDrop(addr)) begin
      mWe   = 1'b1;
      mAddr = addr;
      mData = data;
    end
  endtask

  // Drive one cycle of inputs, check readies, advance the model, check the write port
  task automatic applyStimulus(input logic aV, input logic [4:0] aAddr, input logic [31:0] aData,
                               input logic bV, input logic [4:0] bAddr, input logic [31:0] bData);
    bit          empty;
    bit          expARdy;
    bit          expBRdy;
    bit          aFire;
    logic [36:0] head;
    @(negedge clk);
    bus.i_a_vld  = aV;
    bus.i_a_addr = aAddr;
    bus.i_a_data = aData;
    bus.i_b_vld  = bV;
    bus.i_b_addr = bAddr;
    bus.i_b_data = bData;
    #1;
    empty   = (aQ.size() == 0);
    expARdy = (aQ.size() < FIFO_DEPTH);
    expBRdy = bV && (mBoost || (empty && !aV));
    checkOutput("a_rdy", 64'(bus.o_a_rdy), 64'(expARdy));
    checkOutput("b_rdy", 64'(bus.o_b_rdy), 64'(expBRdy));
    aFire = aV && expARdy;
    mWe   = 1'b0;
    if (mBoost) begin
      if (bV) modelWrite(bAddr, bData);
      if (aFire && !isZeroDrop(aAddr)) aQ.push_back({aAddr, aData});
    end else if (!empty) begin
      head = aQ.pop_front();
      modelWrite(head[36:32], head[31:0]);
      if (aFire && !isZeroDrop(aAddr)) aQ.push_back({aAddr, aData});
    end else if (aV) begin
      modelWrite(aAddr, aData);
    end else if (bV) begin
      modelWrite(bAddr, bData);
    end
    if (!bV || expBRdy) begin
      mWait = 0;
    end else if (!mBoost) begin
      mWait = mWait + 1;
    end
    mBoost     = !mBoost && (mWait == WAIT_MAX);
    mAAccepted = aFire;
    mBAccepted = bV && expBRdy;
    @(posedge clk);
    #1;
    checkOutput("rf_we", 64'(bus.o_rf_we), 64'(mWe));
    checkOutput("rf_addr", 64'(bus.o_rf_addr), 64'(mAddr));
    checkOutput("rf_data", 64'(bus.o_rf_data), 64'(mData));
  endtask

  // Randomized traffic; each source holds its request until the model says it was accepted
  task automatic runRandom(input int cycles, input int aPct, input int bPct);
    for (int i = 0; i < cycles; i++) begin
      if (!curAV || mAAccepted) begin
        curAV    = ($urandom_range(99) < aPct);
        curAAddr = 5'($urandom_range(31));
        curAData = $urandom;
      end
      if (!curBV || mBAccepted) begin
        curBV    = ($urandom_range(99) < bPct);
        curBAddr = 5'($urandom_range(31));
        curBData = $urandom;
      end
      applyStimulus(curAV, curAAddr, curAData, curBV, curBAddr, curBData);
    end
  endtask

  initial begin
    logic bHeld;
    int   guard;
    modelReset();
    bus.i_a_vld  = 1'b0;
    bus.i_a_addr = 5'd0;
    bus.i_a_data = 32'd0;
    bus.i_b_vld  = 1'b0;
    bus.i_b_addr = 5'd0;
    bus.i_b_data = 32'd0;
    rst = 1'b1;
    #12;
    checkOutput("reset_rf_we", 64'(bus.o_rf_we), 64'd0);
    checkOutput("reset_rf_addr", 64'(bus.o_rf_addr), 64'd0);
    checkOutput("reset_a_rdy", 64'(bus.o_a_rdy), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle after reset");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("[TB] A-only stream");
    applyStimulus(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 5'(i + 1), 32'h200 + i, 1'b0, 5'd0, 32'd0);

    $display("[TB] B waiting behind continuous A");
    bHeld = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 5'(10 + i), 32'h100 + i, bHeld, 5'd9, 32'hBEEF);
      if (mBAccepted) bHeld = 1'b0;
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("[TB] FIFO fill, A stall, release");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 5'(i + 3), 32'h3000 + i, 1'b1, 5'd17, 32'h5000 + i);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd18, 32'h6000 + i);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 5'(i + 20), 32'h7000 + i, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("[TB] zero-register request");
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("[TB] reset with buffered entries");
    guard = 0;
    while (aQ.size() < 2 && guard < 60) begin
      applyStimulus(1'b1, 5'(guard % 30 + 1), 32'h8000 + guard, 1'b1, 5'd21, 32'h9000 + guard);
      guard++;
    end
    bus.i_a_vld = 1'b0;
    bus.i_b_vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_rf_we", 64'(bus.o_rf_we), 64'd0);
    checkOutput("midreset_a_rdy", 64'(bus.o_a_rdy), 64'd1);
    checkOutput("midreset_rf_data", 64'(bus.o_rf_data), 64'd0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("[TB] randomized traffic");
    curAV = 1'b0;
    curBV = 1'b0;
    runRandom(200, 90, 60);
    runRandom(200, 50, 40);
    runRandom(100, 100, 100);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
